// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute strobe sequencer for the bus datapath
//
// Purpose: steps through T0..T5 (plus a terminal HALT step) and decodes the
// registered step together with the live IR value into one set of datapath
// control strobes per clock.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high; forces step to T0 and all outputs to 0
//   IR         current instruction register value (opcode/Ra/Rb/Rc fields)
//   PCin..OUTPUTin, Read/Write     register load and memory strobes
//   INPUTout..BAout                bus drive selects
//   GPRin / GPRout                 one-hot register-file write enable / bus drive
//   ADD..IncPC                     ALU operation, at most one high
//   halted                         high while parked in HALT
module control_sequencer #(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITS-1:0]      IR,
  output logic                 PCin,
  output logic                 IRin,
  output logic                 RYin,
  output logic                 RZin,
  output logic                 MARin,
  output logic                 HILOin,
  output logic                 MDRin,
  output logic                 OUTPUTin,
  output logic                 Read,
  output logic                 Write,
  output logic                 INPUTout,
  output logic                 MDRout,
  output logic                 HILOout,
  output logic                 RZout,
  output logic                 PCout,
  output logic                 BAout,
  output logic [REGISTERS-1:0] GPRin,
  output logic [REGISTERS-1:0] GPRout,
  output logic                 ADD,
  output logic                 SUB,
  output logic                 MUL,
  output logic                 DIV,
  output logic                 SHR,
  output logic                 SHL,
  output logic                 ROR,
  output logic                 ROL,
  output logic                 AND,
  output logic                 OR,
  output logic                 NEGATE,
  output logic                 NOT,
  output logic                 IncPC,
  output logic                 halted
);

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    HALT = 3'd6
  } step_t;

  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_NEG  = 5'b01010;
  localparam logic [4:0] OP_NOT  = 5'b01011;
  localparam logic [4:0] OP_LD   = 5'b01100;
  localparam logic [4:0] OP_ST   = 5'b01101;
  localparam logic [4:0] OP_IN   = 5'b01110;
  localparam logic [4:0] OP_OUT  = 5'b01111;
  localparam logic [4:0] OP_MFLO = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  step_t step_q, step_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu3, is_unary, is_muldiv;
  logic       unused_ir;

  assign opcode = IR[31:27];
  assign ra     = IR[26:23];
  assign rb     = IR[22:19];
  assign rc     = IR[18:15];

  // add..rol occupy 00000..00111, so the top two opcode bits classify them.
  assign is_alu3   = (opcode[4:3] == 2'b00);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);

  // Low IR bits carry immediates this sequencer never looks at.
  assign unused_ir = ^(IR & ~BITS'(32'hFFFF_8000));

  function automatic logic [REGISTERS-1:0] reg_sel(input logic [3:0] idx);
    reg_sel = {{(REGISTERS-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= T0;
    end else begin
      step_q <= step_d;
    end
  end

  always_comb begin
    step_d   = T0;
    PCin     = 1'b0;
    IRin     = 1'b0;
    RYin     = 1'b0;
    RZin     = 1'b0;
    MARin    = 1'b0;
    HILOin   = 1'b0;
    MDRin    = 1'b0;
    OUTPUTin = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    INPUTout = 1'b0;
    MDRout   = 1'b0;
    HILOout  = 1'b0;
    RZout    = 1'b0;
    PCout    = 1'b0;
    BAout    = 1'b0;
    GPRin    = '0;
    GPRout   = '0;
    ADD      = 1'b0;
    SUB      = 1'b0;
    MUL      = 1'b0;
    DIV      = 1'b0;
    SHR      = 1'b0;
    SHL      = 1'b0;
    ROR      = 1'b0;
    ROL      = 1'b0;
    AND      = 1'b0;
    OR       = 1'b0;
    NEGATE   = 1'b0;
    NOT      = 1'b0;
    IncPC    = 1'b0;
    halted   = 1'b0;

    // Reset gates the strobes combinationally so an aborted instruction
    // cannot emit its current step even in the cycle reset is first seen.
    if (!reset) begin
      case (step_q)
        T0: begin
          PCout  = 1'b1;
          MARin  = 1'b1;
          IncPC  = 1'b1;
          RZin   = 1'b1;
          step_d = T1;
        end

        T1: begin
          RZout  = 1'b1;
          PCin   = 1'b1;
          Read   = 1'b1;
          MDRin  = 1'b1;
          step_d = T2;
        end

        T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
          step_d = T3;
        end

        T3: begin
          if (is_alu3) begin
            GPRout = reg_sel(rb);
            RYin   = 1'b1;
            step_d = T4;
          end else if (is_unary) begin
            GPRout = reg_sel(rb);
            NEGATE = (opcode == OP_NEG);
            NOT    = (opcode == OP_NOT);
            RZin   = 1'b1;
            step_d = T4;
          end else if (is_muldiv) begin
            GPRout = reg_sel(ra);
            RYin   = 1'b1;
            step_d = T4;
          end else begin
            case (opcode)
              OP_LD, OP_ST: begin
                // BAout marks R0 as a base-address operand (reads as zero).
                GPRout = reg_sel(rb);
                MARin  = 1'b1;
                BAout  = (rb == 4'd0);
                step_d = T4;
              end
              OP_IN: begin
                INPUTout = 1'b1;
                GPRin    = reg_sel(ra);
              end
              OP_OUT: begin
                GPRout   = reg_sel(ra);
                OUTPUTin = 1'b1;
              end
              OP_MFLO: begin
                HILOout = 1'b1;
                GPRin   = reg_sel(ra);
              end
              OP_HALT: step_d = HALT;
              default: step_d = T0;
            endcase
          end
        end

        T4: begin
          if (is_alu3) begin
            GPRout = reg_sel(rc);
            RZin   = 1'b1;
            step_d = T5;
            case (opcode[2:0])
              3'd0:    ADD = 1'b1;
              3'd1:    SUB = 1'b1;
              3'd2:    AND = 1'b1;
              3'd3:    OR  = 1'b1;
              3'd4:    SHR = 1'b1;
              3'd5:    SHL = 1'b1;
              3'd6:    ROR = 1'b1;
              default: ROL = 1'b1;
            endcase
          end else if (is_unary) begin
            RZout = 1'b1;
            GPRin = reg_sel(ra);
          end else if (is_muldiv) begin
            GPRout = reg_sel(rb);
            MUL    = (opcode == OP_MUL);
            DIV    = (opcode == OP_DIV);
            RZin   = 1'b1;
            step_d = T5;
          end else if (opcode == OP_LD) begin
            Read   = 1'b1;
            MDRin  = 1'b1;
            step_d = T5;
          end else if (opcode == OP_ST) begin
            // MDR loads from the bus here, so the memory read stays off.
            GPRout = reg_sel(ra);
            MDRin  = 1'b1;
            step_d = T5;
          end
        end

        T5: begin
          if (is_alu3) begin
            RZout = 1'b1;
            GPRin = reg_sel(ra);
          end else if (is_muldiv) begin
            RZout  = 1'b1;
            HILOin = 1'b1;
          end else if (opcode == OP_LD) begin
            MDRout = 1'b1;
            GPRin  = reg_sel(ra);
          end else if (opcode == OP_ST) begin
            Write = 1'b1;
          end
        end

        HALT: begin
          halted = 1'b1;
          step_d = HALT;
        end

        default: step_d = T0;
      endcase
    end
  end

endmodule
